// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for serial_add_sub.
// i_sub exists only when SUB_EN is defined.
interface serial_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
`ifdef SUB_EN
    logic             i_sub;
`endif
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_carry;
    logic             o_overflow;

    modport master (
`ifdef SUB_EN
        output i_sub,
`endif
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_carry, o_overflow
    );

    modport slave (
`ifdef SUB_EN
        input  i_sub,
`endif
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_carry, o_overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Define SUB_EN to add the i_sub port and subtract mode (A + ~B + 1).
module serial_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_sub_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_BIT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   sa_r;
    logic [WIDTH-1:0]   sb_r;
    logic [WIDTH-2:0]   res_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic               c_msb_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_out_r;
    logic               ovf_r;
    logic               ready_r;
    logic               valid_r;
    logic               sub_mode_s;
    logic               sub_in_s;
    logic               y_s;
    logic               sum_s;
    logic               cout_s;
    logic [WIDTH-1:0]   res_nxt_s;
    logic               last_bit_s;
    logic               msb_in_bit_s;

`ifdef SUB_EN
    logic               sub_r;
    assign sub_in_s   = bus.i_sub;
    assign sub_mode_s = sub_r;

    // Mode latch, captured only on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_r <= 1'b0;
        end else if (state_r == IDLE && bus.i_valid) begin
            sub_r <= sub_in_s;
        end
    end
`else
    assign sub_in_s   = 1'b0;
    assign sub_mode_s = 1'b0;
`endif

    // Full-adder cell and bit-position decode
    always_comb begin
        y_s          = sb_r[0] ^ sub_mode_s;
        sum_s        = fa_sum(sa_r[0], y_s, carry_r);
        cout_s       = fa_carry(sa_r[0], y_s, carry_r);
        res_nxt_s    = {sum_s, res_r};
        last_bit_s   = (cnt_r == LAST_BIT);
        msb_in_bit_s = (cnt_r == PENULT_BIT);
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.i_valid) state_nxt_s = RUN;
                else             state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_bit_s) state_nxt_s = DONE;
                else            state_nxt_s = RUN;
            end
            DONE: begin
                if (bus.i_ready) state_nxt_s = IDLE;
                else             state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            valid_r <= (state_nxt_s == DONE);
        end
    end

    // Serial datapath: operand shifters, carry flop, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_r        <= {WIDTH{1'b0}};
            sb_r        <= {WIDTH{1'b0}};
            res_r       <= {(WIDTH-1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            carry_r     <= 1'b0;
            c_msb_r     <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.i_valid) begin
                        sa_r    <= bus.i_a;
                        sb_r    <= bus.i_b;
                        carry_r <= sub_in_s;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
                    res_r   <= res_nxt_s[WIDTH-1:1];
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (msb_in_bit_s) begin
                        c_msb_r <= cout_s;
                    end
                    // Signed overflow: carry into the MSB differs from carry out of it
                    if (last_bit_s) begin
                        result_r    <= res_nxt_s;
                        carry_out_r <= cout_s;
                        ovf_r       <= c_msb_r ^ cout_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready_r;
    assign bus.o_valid    = valid_r;
    assign bus.o_result   = result_r;
    assign bus.o_carry    = carry_out_r;
    assign bus.o_overflow = ovf_r;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub with a result scoreboard.
module tb_serial_add_sub;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(WIDTH)) bus();
    serial_add_sub #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit sub);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        bb      = sub ? ~b : b;
        full    = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub);
        e.res   = full[WIDTH-1:0];
        e.carry = full[WIDTH];
        e.ovf   = (a[WIDTH-1] == bb[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    task automatic set_sub(input bit s);
`ifdef SUB_EN
        bus.i_sub = s;
`else
        if (s) $display("[TB] subtract requested in add-only build");
`endif
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit sub, input int hold, input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, "_ready_idle"}, 64'(bus.o_ready), 64'd1);
        bus.i_a     = a;
        bus.i_b     = b;
        set_sub(sub);
        bus.i_valid = 1'b1;
        bus.i_ready = (hold == 0);
        sb_q.push_back(model(a, b, sub));
        @(negedge clk);
        // Operands must be ignored once accepted
        bus.i_valid = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
        set_sub(~sub);
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < WIDTH + 4) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(WIDTH));
        e = sb_q.pop_front();
        check({tag, "_result"},   64'(bus.o_result),   64'(e.res));
        check({tag, "_carry"},    64'(bus.o_carry),    64'(e.carry));
        check({tag, "_overflow"}, 64'(bus.o_overflow), 64'(e.ovf));
        check({tag, "_ready_done"}, 64'(bus.o_ready),  64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.i_a     = $urandom;
            bus.i_b     = $urandom;
            bus.i_valid = i[0];
            @(negedge clk);
            check({tag, "_hold_valid"},  64'(bus.o_valid),    64'd1);
            check({tag, "_hold_ready"},  64'(bus.o_ready),    64'd0);
            check({tag, "_hold_result"}, 64'(bus.o_result),   64'(e.res));
            check({tag, "_hold_carry"},  64'(bus.o_carry),    64'(e.carry));
            check({tag, "_hold_ovf"},    64'(bus.o_overflow), 64'(e.ovf));
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check({tag, "_valid_after"},  64'(bus.o_valid),  64'd0);
        check({tag, "_ready_after"},  64'(bus.o_ready),  64'd1);
        check({tag, "_result_kept"},  64'(bus.o_result), 64'(e.res));
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        set_sub(1'b0);
        repeat (2) @(negedge clk);
        check("rst_ready",    64'(bus.o_ready),    64'd1);
        check("rst_valid",    64'(bus.o_valid),    64'd0);
        check("rst_result",   64'(bus.o_result),   64'd0);
        check("rst_carry",    64'(bus.o_carry),    64'd0);
        check("rst_overflow", 64'(bus.o_overflow), 64'd0);
        rst = 1'b0;

        do_op(32'd5,          32'd7,          1'b0, 0, "add_5_7");
        do_op(32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 0, "add_wrap");
        do_op(32'h7FFF_FFFF,  32'h0000_0001,  1'b0, 0, "add_posovf");
        do_op(32'h8000_0000,  32'h8000_0000,  1'b0, 0, "add_negovf");
`ifdef SUB_EN
        do_op(32'd5,          32'd7,          1'b1, 0, "sub_5_7");
        do_op(32'h8000_0000,  32'h0000_0001,  1'b1, 0, "sub_ovf");
        do_op(32'h1234_5678,  32'h1234_5678,  1'b1, 0, "sub_equal");
`endif
        do_op(32'hA5A5_1234,  32'h5A5A_4321,  1'b0, 10, "backpressure");

        // Abort an operation 10 cycles after accept
        @(negedge clk);
        bus.i_a     = 32'h1357_9BDF;
        bus.i_b     = 32'h2468_ACE0;
        set_sub(1'b0);
        bus.i_valid = 1'b1;
        sb_q.push_back(model(32'h1357_9BDF, 32'h2468_ACE0, 1'b0));
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        sb_q.delete();
        check("midrst_valid",    64'(bus.o_valid),    64'd0);
        check("midrst_ready",    64'(bus.o_ready),    64'd1);
        check("midrst_result",   64'(bus.o_result),   64'd0);
        check("midrst_carry",    64'(bus.o_carry),    64'd0);
        check("midrst_overflow", 64'(bus.o_overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd3, 32'd4, 1'b0, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor built around a single full-adder cell plus a carry flop.
- Processes one bit per clock, LSB first, over WIDTH cycles.
- Area-cheap alternative to the ripple-carry adder for the ALU's multi-cycle ops path.
- Valid/ready handshakes on the operand side and the result side.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- i_valid  input  1  operands valid
- o_ready  output  1  block can accept operands
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_sub  input  1  1 = A-B, 0 = A+B; present only with SUB_EN
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_result  output  WIDTH  sum/difference
- o_carry  output  1  final carry-out; for subtract, 1 = no borrow
- o_overflow  output  1  signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: FSM=IDLE, o_ready=1, o_valid=0, o_result=0, o_carry=0, o_overflow=0, internal shift registers, counter and carry flop = 0.
- Reset asserted mid-operation aborts the operation immediately. No result is produced and the block returns to IDLE.
- FSM states: IDLE, RUN, DONE.
- o_ready = 1 only in IDLE. o_valid = 1 only in DONE.
- IDLE, edge with i_valid=1:
  - latch A into shift register SA, B into SB, mode into sub_q;
  - carry flop = sub_q (1 for subtract, 0 for add);
  - bit counter = 0; go to RUN.
  - i_valid=0: stay in IDLE.
- RUN, each edge (one full-adder step):
  - x = SA[0], y = SB[0] XOR sub_q, c = carry flop;
  - s = x^y^c, cout = (x&y)|(x&c)|(y&c);
  - shift SA and SB right by one; shift s into the MSB of the result register;
  - carry flop = cout; counter += 1.
  - On the edge processing bit WIDTH-2, also capture cout into c_msb_in (carry into MSB).
  - On the edge processing bit WIDTH-1:
    - o_result = the completed result register;
    - o_carry = cout; o_overflow = c_msb_in XOR cout;
    - go to DONE.
- Latency: o_valid rises exactly WIDTH cycles after the accept edge.
- DONE:
  - o_result, o_carry and o_overflow are held stable while i_ready=0.
  - Edge with i_ready=1: go to IDLE; o_valid drops after that edge.
  - Outputs keep their last values in IDLE until the next result overwrites them.
- Throughput: one operation per WIDTH+2 cycles minimum. i_valid is ignored outside IDLE.
- Arithmetic:
  - modulo 2^WIDTH;
  - subtract is A + ~B + 1, using the inverted second input with carry-in 1;
  - overflow is the two's-complement signed overflow of the full-width op.
- i_a, i_b and i_sub are sampled only on the accept edge. Later changes have no effect.

Optional Feature:
- Macro SUB_EN.
- Defined: i_sub port exists. The B input of the full-adder cell is XORed with sub_q, and the carry flop initialises to sub_q.
- Undefined: i_sub port is absent. sub_q is tied to 0, the block is add-only, and the carry flop initialises to 0.
- Add results are identical in both builds.

Test Plan:
- WIDTH=32, add, A=5, B=7, i_ready=1 -> o_valid high 32 cycles after accept; o_result=0x0000000C, o_carry=0, o_overflow=0; o_ready back to 1 the cycle after the DONE handshake.
- Add, A=0xFFFFFFFF, B=0x00000001 -> o_result=0x00000000, o_carry=1, o_overflow=0.
- Add, A=0x7FFFFFFF, B=0x00000001 -> o_result=0x80000000, o_carry=0, o_overflow=1.
- SUB_EN build:
  - i_sub=1, A=5, B=7 -> o_result=0xFFFFFFFE, o_carry=0 (borrow), o_overflow=0;
  - i_sub=1, A=0x80000000, B=1 -> o_result=0x7FFFFFFF, o_carry=1, o_overflow=1.
- Backpressure: hold i_ready=0 for 10 cycles in DONE, and toggle i_a/i_b/i_valid meanwhile -> o_valid stays 1, outputs unchanged, o_ready stays 0; a single i_ready=1 pulse returns the block to IDLE.
- Reset mid-run: assert rst 10 cycles into an operation -> immediately o_valid=0, o_ready=1, all outputs 0. A following A=3, B=4 add completes normally with o_result=7.
